// File: rtl/mac_tx_frame_fifo.sv
// -----------------------------------------------------------------------------
// mac_tx_frame_fifo
//
// Frame-aware transmit FIFO for a MAC. Words of a frame are written in
// order and become readable only once the frame's final word (wr_last)
// has been written. A frame being written can be discarded with wr_abort.
// A write that meets a full FIFO drops the rest of that frame, so a
// partial frame is never committed.
//
// Three pointers, each ADDR_W+1 bits wide, wrap freely:
//   wr_ptr  - next entry to write (includes the uncommitted frame)
//   cmt_ptr - end of the last committed frame
//   rd_ptr  - next entry to read
//
// Handshake semantics: a write is taken on any cycle with wr_en high while
// full is low and no frame is being dropped. A read is taken on any cycle
// with rd_en high while empty is low. The read word appears on
// rd_data/rd_last exactly one cycle later, qualified by rd_valid. There is
// no back-pressure on the read side; rd_en while empty is ignored.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   wr_en        write one word this cycle
//   wr_data      word to write
//   wr_last      written word is the final word of its frame
//   wr_abort     discard the frame currently being written
//   rd_en        request one word
//   rd_data      registered read word
//   rd_valid     rd_data/rd_last valid this cycle
//   rd_last      rd_data is the final word of its frame
//   full         no free entry
//   almost_full  occupancy >= AFULL_LVL
//   empty        no committed word readable
//   occupancy    entries held, committed plus uncommitted
//   frame_cnt    committed frames not yet fully read
//   overflow     one-cycle pulse when a write is dropped
// -----------------------------------------------------------------------------
module mac_tx_frame_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 7,
    parameter int AFULL_LVL = (1 << ADDR_W) - 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              wr_abort,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    output logic              full,
    output logic              almost_full,
    output logic              empty,
    output logic [ADDR_W:0]   occupancy,
    output logic [ADDR_W:0]   frame_cnt,
    output logic              overflow
);

    localparam logic [ADDR_W:0] DEPTH   = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] AFULL_V = (ADDR_W+1)'(AFULL_LVL);

    // Write-side state: PASS accepts words, DROP discards the remainder of
    // a frame that overflowed until its last word or an abort.
    typedef enum logic {
        WR_PASS = 1'b0,
        WR_DROP = 1'b1
    } wr_state_t;

    wr_state_t wr_state, wr_state_nxt;

    logic [DATA_W:0] mem [0:(1 << ADDR_W)-1];

    logic [ADDR_W:0] wr_ptr, cmt_ptr, rd_ptr;
    logic [ADDR_W:0] wr_ptr_nxt;
    logic            wr_accept;
    logic            commit;
    logic            rewind;
    logic            overflow_nxt;
    logic            rd_accept;
    logic            rd_dec;
    logic [DATA_W:0] rd_word;

    // Flags come straight from the registered pointers.
    assign occupancy   = wr_ptr - rd_ptr;
    assign full        = (occupancy == DEPTH);
    assign almost_full = (occupancy >= AFULL_V);
    assign empty       = (rd_ptr == cmt_ptr);

    assign rd_accept = rd_en & ~empty;
    assign rd_word   = mem[rd_ptr[ADDR_W-1:0]];
    assign rd_dec    = rd_accept & rd_word[DATA_W];

    always_comb begin
        wr_state_nxt = wr_state;
        wr_accept    = 1'b0;
        commit       = 1'b0;
        rewind       = 1'b0;
        overflow_nxt = 1'b0;
        case (wr_state)
            WR_PASS: begin
                if (wr_abort) begin
                    // Abort wins over any write in the same cycle.
                    rewind = 1'b1;
                end else if (wr_en && full) begin
                    overflow_nxt = 1'b1;
                    if (wr_last) begin
                        // The dropped word closed its frame; discard it now.
                        rewind = 1'b1;
                    end else begin
                        wr_state_nxt = WR_DROP;
                    end
                end else if (wr_en) begin
                    wr_accept = 1'b1;
                    commit    = wr_last;
                end
            end
            WR_DROP: begin
                if (wr_abort || (wr_en && wr_last)) begin
                    rewind       = 1'b1;
                    wr_state_nxt = WR_PASS;
                end
            end
            default: wr_state_nxt = WR_PASS;
        endcase

        if (rewind) begin
            wr_ptr_nxt = cmt_ptr;
        end else if (wr_accept) begin
            wr_ptr_nxt = wr_ptr + 1'b1;
        end else begin
            wr_ptr_nxt = wr_ptr;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state  <= WR_PASS;
            wr_ptr    <= '0;
            cmt_ptr   <= '0;
            rd_ptr    <= '0;
            frame_cnt <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wr_state <= wr_state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            overflow <= overflow_nxt;
            if (commit) begin
                cmt_ptr <= wr_ptr + 1'b1;
            end

            rd_valid <= rd_accept;
            if (rd_accept) begin
                rd_data <= rd_word[DATA_W-1:0];
                rd_last <= rd_word[DATA_W];
                rd_ptr  <= rd_ptr + 1'b1;
            end

            // A commit and a last-word read in the same cycle cancel out.
            case ({commit, rd_dec})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

endmodule

// File: doc/mac_tx_frame_fifo.md
MAC_TX_FRAME_FIFO -- requirements
Module: mac_tx_frame_fifo

Interface
REQ-001 Parameter DATA_W, default 8: data byte/word width in bits.
REQ-002 Parameter ADDR_W, default 7: depth DEPTH = 2^ADDR_W entries (default 128).
REQ-003 Parameter AFULL_LVL, default 2^ADDR_W-16: occupancy at or above which almost_full asserts.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  write one word this cycle.
REQ-007 wr_data  input  DATA_W  word to write.
REQ-008 wr_last  input  1  qualifies wr_en; word is final word of frame.
REQ-009 wr_abort  input  1  discard frame currently being written.
REQ-010 rd_en  input  1  request one word.
REQ-011 rd_data  output  DATA_W  registered read word.
REQ-012 rd_valid  output  1  rd_data/rd_last valid this cycle.
REQ-013 rd_last  output  1  rd_data is final word of its frame.
REQ-014 full  output  1  no free entry.
REQ-015 almost_full  output  1  occupancy >= AFULL_LVL.
REQ-016 empty  output  1  no committed word readable.
REQ-017 occupancy  output  ADDR_W+1  entries held, committed plus uncommitted.
REQ-018 frame_cnt  output  ADDR_W+1  committed frames not yet fully read.
REQ-019 overflow  output  1  one-cycle pulse on dropped write.

Function
REQ-020 Storage: DEPTH x (DATA_W+1) array; extra bit stores wr_last.
REQ-021 Pointers wr_ptr, cmt_ptr, rd_ptr are ADDR_W+1 bits; low ADDR_W bits address; wrap modulo 2^(ADDR_W+1) without special cases.
REQ-022 occupancy = wr_ptr - rd_ptr; full = (occupancy == DEPTH); all flags combinational from registered pointers.
REQ-023 empty = (rd_ptr == cmt_ptr); uncommitted words never readable.
REQ-024 Accepted write: wr_en & ~full & ~drop_state -> store {wr_last, wr_data} at wr_ptr, wr_ptr+1.
REQ-025 Commit: accepted write with wr_last & ~wr_abort -> cmt_ptr <= wr_ptr+1 same edge; frame_cnt+1.
REQ-026 Abort: wr_abort -> wr_ptr <= cmt_ptr, any same-cycle write ignored; abort beats wr_last.
REQ-027 Overflow: wr_en & full -> word dropped, overflow pulses 1 cycle, enter drop_state.
REQ-028 drop_state: further wr_en ignored (no overflow pulse); on wr_en&wr_last or wr_abort, wr_ptr <= cmt_ptr, leave drop_state; partial frame never committed.
REQ-029 Accepted read: rd_en & ~empty -> rd_data/rd_last from rd_ptr next cycle with rd_valid=1; rd_ptr+1; latency exactly 1.
REQ-030 rd_en & empty ignored; rd_valid=0 next cycle; rd_data holds last value.
REQ-031 Reading a word with stored last bit decrements frame_cnt; simultaneous commit and last-read leave it unchanged.
REQ-032 Simultaneous accepted read and write in one cycle both take effect; full cycle read frees entry only next cycle.
REQ-033 Write to entry being read same cycle impossible (distinct addresses by REQ-022/023).

Reset
REQ-034 rst: wr_ptr=cmt_ptr=rd_ptr=0, drop_state=0, frame_cnt=0, rd_data=0, rd_valid=0, rd_last=0, overflow=0.
REQ-035 Post-reset flags: empty=1, full=0, almost_full=0, occupancy=0; array contents not reset.
REQ-036 rst mid-frame or mid-read discards all data; takes priority over all inputs.

Verification
REQ-037 Write 4-word frame 0x11..0x14, wr_last on 0x14 -> empty stays 1 until edge after 0x14, frame_cnt=1; 4 reads -> 0x11..0x14, rd_last only with 0x14, frame_cnt=0, empty=1.
REQ-038 Write 3 words then wr_abort -> occupancy 0, empty=1, frame_cnt=0; next frame reads back intact.
REQ-039 Default params: 128 writes no wr_last -> full=1, almost_full from occupancy 112; 129th write -> overflow pulse; wr_last -> occupancy 0.
REQ-040 Stream 300 single-word frames with simultaneous read/write each cycle -> data in order across pointer wrap, occupancy <= 2.
REQ-041 rd_en when empty -> rd_valid=0, rd_data unchanged; rst during frame -> all REQ-034 values next cycle.
REQ-042 wr_last and wr_abort same cycle -> frame discarded, frame_cnt unchanged.
